// File: rtl/rv32i_fetch_pkg.sv
// rv32i_fetch_pkg: shared types and constants for the RV32I instruction fetch unit
//   fetch_state_e    FSM states BOOT, FETCH, EXEC, FAULT
//   DEF_RESET_PC     default PC loaded on reset
//   DEF_NOP_INSN     default instruction shown while nothing valid is held (ADDI x0,x0,0)
//   WORD_ALIGN_MASK  clears the byte offset of a 32-bit word address
package rv32i_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSN    = 32'h0000_0013;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter register with async active-low reset and load enable
//   clk      in   core clock
//   reset_n  in   asynchronous active-low reset, loads RESET_PC
//   load     in   take pc_next on the next rising edge
//   pc_next  in   32-bit target address
//   pc       out  current program counter
// Build option FETCH_MISALIGN_CHECK_EN: when defined the target is loaded unmodified
// (the fault is raised by the parent); otherwise the byte offset is forced to zero.
module fetch_pc_reg
    import rv32i_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [31:0] pc_next,
    output logic [31:0] pc
);

    logic [31:0] pc_d, pc_q, target;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign target = pc_next;
`else
    assign target = align_word(pc_next);
`endif

    always_comb pc_d = load ? target : pc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pc_q <= RESET_PC;
        else          pc_q <= pc_d;
    end

    assign pc = pc_q;

endmodule

// File: rtl/insn_fetch_unit.sv
// insn_fetch_unit: RV32I fetch stage; owns PC and instruction register, fetches over req/ack
//   clk, reset_n          core clock, asynchronous active-low reset
//   imem_req/imem_addr    fetch request and word address (= pc), stable until imem_ack
//   imem_ack/imem_rdata   memory response
//   insn/insn_pc          held instruction and its address, feed the decoder
//   insn_valid            insn holds a fetched, not-yet-retired instruction
//   exec_done/pc_next     retire pulse and the next PC sampled with it
//   insn_count            retired-instruction counter, wraps silently
//   fault                 misaligned-target fault
// Build option FETCH_MISALIGN_CHECK_EN: when defined a misaligned pc_next on retire
// enters the terminal FAULT state; otherwise fault is tied to 0.
module insn_fetch_unit
    import rv32i_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSN = DEF_NOP_INSN
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] insn,
    output logic [31:0] insn_pc,
    output logic        insn_valid,
    input  logic        exec_done,
    input  logic [31:0] pc_next,
    output logic [31:0] insn_count,
    output logic        fault
);

    fetch_state_e state_d, state_q;
    logic         req_d, req_q;
    logic         valid_d, valid_q;
    logic [31:0]  insn_d, insn_q;
    logic [31:0]  insn_pc_d, insn_pc_q;
    logic [31:0]  count_d, count_q;
    logic [31:0]  pc;
    logic         retire;
    logic         misaligned;

    // Events outside their own state are ignored by gating on the state here.
    assign retire = (state_q == EXEC) && exec_done;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misaligned = |pc_next[1:0];
`else
    assign misaligned = 1'b0;
`endif

    fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (retire),
        .pc_next (pc_next),
        .pc      (pc)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        valid_d   = valid_q;
        insn_d    = insn_q;
        insn_pc_d = insn_pc_q;
        count_d   = count_q;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
                req_d   = 1'b1;
            end
            FETCH: if (imem_ack) begin
                state_d   = EXEC;
                req_d     = 1'b0;
                valid_d   = 1'b1;
                insn_d    = imem_rdata;
                insn_pc_d = pc;
            end
            EXEC: if (exec_done) begin
                state_d = misaligned ? FAULT : FETCH;
                req_d   = !misaligned;
                valid_d = 1'b0;
                insn_d  = NOP_INSN;
                count_d = count_q + 32'd1;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= BOOT;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            insn_q    <= NOP_INSN;
            insn_pc_q <= RESET_PC;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
            insn_q    <= insn_d;
            insn_pc_q <= insn_pc_d;
            count_q   <= count_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc;
    assign insn       = insn_q;
    assign insn_pc    = insn_pc_q;
    assign insn_valid = valid_q;
    assign insn_count = count_q;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign fault = (state_q == FAULT);
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_insn_fetch_unit.sv
// tb_insn_fetch_unit: directed self-checking bench for insn_fetch_unit
module tb_insn_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        insn_valid;
    logic        exec_done = 1'b0;
    logic [31:0] pc_next = '0;
    logic [31:0] insn_count;
    logic        fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    insn_fetch_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .insn       (insn),
        .insn_pc    (insn_pc),
        .insn_valid (insn_valid),
        .exec_done  (exec_done),
        .pc_next    (pc_next),
        .insn_count (insn_count),
        .fault      (fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic reset_state(input string tag);
        check({tag, "_req"}, 32'(imem_req), 32'd0);
        check({tag, "_insn"}, insn, 32'h0000_0013);
        check({tag, "_insn_pc"}, insn_pc, 32'h0);
        check({tag, "_valid"}, 32'(insn_valid), 32'd0);
        check({tag, "_count"}, insn_count, 32'd0);
        check({tag, "_fault"}, 32'(fault), 32'd0);
    endtask

    task automatic release_and_boot(input string tag);
        @(negedge clk);
        reset_n = 1'b1;
        #1 check({tag, "_boot_req"}, 32'(imem_req), 32'd0);
        @(negedge clk);
        check({tag, "_fetch_req"}, 32'(imem_req), 32'd1);
        check({tag, "_fetch_addr"}, imem_addr, 32'h0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset_state("por");
        release_and_boot("t1");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_wait_req", 32'(imem_req), 32'd1);
            check("t2_wait_addr", imem_addr, 32'h0);
        end
        imem_ack = 1'b1;
        imem_rdata = 32'h0050_0093;
        @(negedge clk);
        imem_ack = 1'b0;
        check("t2_insn", insn, 32'h0050_0093);
        check("t2_insn_pc", insn_pc, 32'h0);
        check("t2_valid", 32'(insn_valid), 32'd1);
        check("t2_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("t2_hold_insn", insn, 32'h0050_0093);
        exec_done = 1'b1;
        pc_next = 32'h0000_0010;
        @(negedge clk);
        exec_done = 1'b0;
        check("t3_addr", imem_addr, 32'h10);
        check("t3_req", 32'(imem_req), 32'd1);
        check("t3_valid", 32'(insn_valid), 32'd0);
        check("t3_count", insn_count, 32'd1);
        check("t3_insn", insn, 32'h0000_0013);
        exec_done = 1'b1;
        pc_next = 32'h0000_0040;
        @(negedge clk);
        exec_done = 1'b0;
        check("t4_ign_done_addr", imem_addr, 32'h10);
        check("t4_ign_done_count", insn_count, 32'd1);
        check("t4_ign_done_req", 32'(imem_req), 32'd1);
        imem_ack = 1'b1;
        imem_rdata = 32'h0010_0113;
        @(negedge clk);
        check("t4_insn", insn, 32'h0010_0113);
        check("t4_insn_pc", insn_pc, 32'h10);
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        check("t4_ign_ack_insn", insn, 32'h0010_0113);
        check("t4_ign_ack_req", 32'(imem_req), 32'd0);
        check("t4_ign_ack_valid", 32'(insn_valid), 32'd1);
        check("t4_ign_ack_count", insn_count, 32'd1);
        check("t4_ign_ack_addr", imem_addr, 32'h10);
        exec_done = 1'b1;
        pc_next = 32'h0000_0006;
        @(negedge clk);
        exec_done = 1'b0;
        check("t6_count", insn_count, 32'd2);
        check("t6_valid", 32'(insn_valid), 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("t6_addr", imem_addr, 32'h6);
        for (int i = 0; i < 5; i++) begin
            check("t6_fault", 32'(fault), 32'd1);
            check("t6_req", 32'(imem_req), 32'd0);
            @(negedge clk);
        end
`else
        check("t6_addr", imem_addr, 32'h4);
        check("t6_req", 32'(imem_req), 32'd1);
        check("t6_fault", 32'(fault), 32'd0);
`endif
        #2 reset_n = 1'b0;
        #1 reset_state("t1_async");
        check("t1_async_addr", imem_addr, 32'h0);
        release_and_boot("t5a");
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("t5_req_now", 32'(imem_req), 32'd0);
        @(negedge clk);
        imem_ack = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem_ack = 1'b0;
        reset_state("t5_ack_ignored");
        release_and_boot("t5b");
        imem_ack = 1'b1;
        imem_rdata = 32'h0030_0193;
        @(negedge clk);
        imem_ack = 1'b0;
        check("t5_refetch_insn", insn, 32'h0030_0193);
        check("t5_refetch_pc", insn_pc, 32'h0);
        check("t5_refetch_count", insn_count, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
